// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   state_t   : responder FSM states (IDLE, BUSY, RESP)
//   STRB_W    : number of byte lanes in a 32-bit word
//   addr_err  : alignment and range check for a byte address
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int STRB_W = 4;

  // The upper bound is computed in 33 bits so that a window ending exactly
  // at 4 GiB does not wrap around to zero.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [32:0] span);
    return (addr[1:0] != 2'b00) ||
           (addr < base) ||
           ({1'b0, addr} >= ({1'b0, base} + span));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32-bit storage, one byte-lane array per lane.
//   clk   : clock
//   we    : write enable, qualified per lane by wstrb
//   wstrb : byte-lane enables
//   wdata : write data
//   re    : read enable; rdata is registered on the edge where re is high
//   idx   : word index shared by read and write
//   rdata : registered read data (not reset)
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [STRB_W-1:0]              wstrb,
  input  logic [31:0]                    wdata,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  output logic [31:0]                    rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] lane_q;

      always_ff @(posedge clk) begin
        if (we && wstrb[gi]) begin
          mem[idx] <= wdata[8*gi +: 8];
        end
        if (re) begin
          lane_q <= mem[idx];
        end
      end

      assign rdata[8*gi +: 8] = lane_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store target with fixed latency.
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid / req_ready : request handshake (req_ready is registered)
//   req_addr, req_we      : byte address, 1 = store
//   req_wstrb, req_wdata  : store byte enables and data
//   rsp_valid             : one-cycle response pulse
//   rsp_rdata             : load data, 0 for stores and errors
//   rsp_err               : misaligned or out-of-range access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_0 = 4'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [31:0]       addr_reg;
  logic              we_reg;
  logic [STRB_W-1:0] wstrb_reg;
  logic [31:0]       wdata_reg;
  logic              ready_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic              rd_sel_reg;

  logic              accept;
  logic              resp_edge;
  logic              err;
  logic [31:0]       offset;
  logic [AW-1:0]     idx;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       array_rdata;

  assign accept    = req_valid && ready_reg;
  // The edge at the end of the last BUSY cycle registers the response; the
  // store commits and the array read is captured on that same edge.
  assign resp_edge = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign err       = addr_err(addr_reg, BASE_ADDR, SPAN);
  assign offset    = addr_reg - BASE_ADDR;
  assign idx       = AW'(offset >> 2);
  assign mem_we    = resp_edge && we_reg && !err;
  assign mem_re    = resp_edge && !we_reg && !err;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = CNT_0;
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = CNT_0;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rd_sel_reg    <= 1'b0;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      wstrb_reg     <= '0;
      wdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ready_reg     <= (state_next == IDLE) || (state_next == RESP);
      rsp_valid_reg <= resp_edge;
      rsp_err_reg   <= resp_edge && err;
      rd_sel_reg    <= mem_re;
      if (accept) begin
        addr_reg  <= req_addr;
        we_reg    <= req_we;
        wstrb_reg <= req_wstrb;
        wdata_reg <= req_wdata;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .wstrb(wstrb_reg),
    .wdata(wdata_reg),
    .re   (mem_re),
    .idx  (idx),
    .rdata(array_rdata)
  );

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  // The array output register is not reset, so it is only exposed during a
  // successful load response.
  assign rsp_rdata = rd_sel_reg ? array_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder
// against a word-array reference model.
module tb_dmem_responder;

  localparam int          DEPTH   = 1024;
  localparam int          LAT     = 2;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_we   (req_we),
    .req_wstrb(req_wstrb),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    return (a % 4 != 0) || (a < longint'(BASE)) || (a >= longint'(BASE) + DEPTH * 4);
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((longint'(addr) - longint'(BASE)) / 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full single transaction; called at posedge+1 with the DUT idle.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wdata);
    int          waitc;
    int          cycles;
    logic        e_err;
    logic [31:0] e_rdata;
    int          w;
    waitc = 0;
    while (!req_ready && waitc < TIMEOUT) begin
      tick();
      waitc++;
    end
    check({tag, "_accept_timeout"}, 32'(waitc < TIMEOUT), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wstrb = strb;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;

    e_err   = exp_err(addr);
    e_rdata = 32'h0;
    if (!e_err) begin
      w = word_of(addr);
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (strb[i]) model[w][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        e_rdata = model[w];
      end
    end

    cycles = 0;
    while (!rsp_valid && cycles < TIMEOUT) begin
      tick();
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'(LAT));
    check({tag, "_err"}, 32'(rsp_err), 32'(e_err));
    check({tag, "_rdata"}, rsp_rdata, e_rdata);
    $display("txn %s we=%0d addr=%h strb=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
             tag, we, addr, strb, wdata, rsp_err, rsp_rdata, cycles);
    tick();
    check({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] ld_addr [3];
    logic [31:0] ld_exp  [3];
    int          n_acc;
    int          n_rsp;
    int          last_acc;
    int          low;
    logic        acc_now;
    logic [31:0] prior;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_we    = 1'b0;
    req_wstrb = 4'h0;
    req_wdata = 32'h0;

    // 1. reset then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    check("rel_ready_before_edge", 32'(req_ready), 32'd0);
    tick();
    check("rel_ready_after_edge", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    end

    // Known contents for words 0..31 so later loads are well defined.
    for (int i = 0; i < 32; i++) begin
      do_req("init", 1'b1, BASE + 32'(i * 4), 4'hF, $urandom);
    end

    // 2. store then load
    do_req("st10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    do_req("ld10", 1'b0, 32'h10, 4'h0, 32'h0);
    check("ld10_value", rsp_rdata, 32'h0);  // pulse over, data back to 0

    // 3. byte strobes
    do_req("st20", 1'b1, 32'h20, 4'hF, 32'h11223344);
    do_req("st20_strb", 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    check("model_strb", model[8], 32'h11BB33DD);
    do_req("ld20", 1'b0, 32'h20, 4'h0, 32'h0);
    do_req("st24_nostrb", 1'b1, 32'h24, 4'h0, 32'hFFFFFFFF);
    do_req("ld24", 1'b0, 32'h24, 4'h0, 32'h0);

    // 4. errors
    do_req("ld_misalign", 1'b0, 32'h22, 4'h0, 32'h0);
    do_req("st_oor", 1'b1, 32'h1000, 4'hF, 32'h12345678);
    do_req("ld_word0", 1'b0, 32'h0, 4'h0, 32'h0);
    do_req("ld_last", 1'b0, 32'hFFC, 4'h0, 32'h0);

    // 5. back-to-back loads with req_valid held high
    ld_addr[0] = 32'h10;
    ld_addr[1] = 32'h20;
    ld_addr[2] = 32'h04;
    for (int i = 0; i < 3; i++) ld_exp[i] = model[word_of(ld_addr[i])];
    n_acc     = 0;
    n_rsp     = 0;
    last_acc  = -1;
    low       = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = ld_addr[0];
    for (int cyc = 0; cyc < 4 * (LAT + 1) + 4; cyc++) begin
      acc_now = req_valid && req_ready;
      if (!req_ready) low++;
      tick();
      if (acc_now) begin
        if (n_acc > 0) begin
          check("b2b_interval", 32'(cyc - last_acc), 32'(LAT + 1));
          check("b2b_ready_low", 32'(low), 32'(LAT));
        end
        low      = 0;
        last_acc = cyc;
        n_acc++;
        if (n_acc == 3) req_valid = 1'b0;
        else req_addr = ld_addr[n_acc];
      end
      if (rsp_valid) begin
        if (n_rsp < 3) check("b2b_rdata", rsp_rdata, ld_exp[n_rsp]);
        n_rsp++;
      end
    end
    check("b2b_accepts", 32'(n_acc), 32'd3);
    check("b2b_responses", 32'(n_rsp), 32'd3);
    $display("txn b2b loads accepted=%0d responses=%0d", n_acc, n_rsp);
    req_valid = 1'b0;
    tick();

    // 6. reset during BUSY drops a pending store
    prior = model[16];
    while (!req_ready) tick();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wstrb = 4'hF;
    req_wdata = 32'h55AA55AA;
    tick();
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    $display("txn reset_mid_store addr=00000040 dropped");
    do_req("ld40", 1'b0, 32'h40, 4'h0, 32'h0);
    check("model_40_unchanged", model[16], prior);

    // Randomized mix over a small initialized window plus error addresses.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          sel;
      a   = BASE + 32'($urandom_range(0, 31) * 4);
      sel = $urandom_range(0, 7);
      if (sel == 0) a = a + 32'($urandom_range(1, 3));
      else if (sel == 1) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 63) * 4);
      do_req("rand", 1'($urandom), a, 4'($urandom), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
